// File: rtl/pu_pkg.sv
// Shared definitions for the processing-unit chain.
// Contents: opcode values claimed by the add/compare PU, compare selector
// codes, the decoded ALU operation type, and a helper that gives the number
// of sign bits to prepend when widening an immediate to register width.
package pu_pkg;

  localparam int OPC_SUB  = 1;
  localparam int OPC_ADD  = 2;
  localparam int OPC_ICMP = 3;
  localparam int OPC_ADDC = 4;

  localparam logic [3:0] CMP_NEQ = 4'd1;
  localparam logic [3:0] CMP_GTU = 4'd2;
  localparam logic [3:0] CMP_GTS = 4'd3;
  localparam logic [3:0] CMP_GEU = 4'd4;
  localparam logic [3:0] CMP_GES = 4'd5;
  localparam logic [3:0] CMP_LTU = 4'd6;
  localparam logic [3:0] CMP_LTS = 4'd7;
  localparam logic [3:0] CMP_LEU = 4'd8;
  localparam logic [3:0] CMP_LES = 4'd9;
  localparam logic [3:0] CMP_EQ  = 4'd10;

  typedef enum logic [1:0] {
    ALU_SUB  = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_ICMP = 2'd2,
    ALU_ADDC = 2'd3
  } alu_op_e;

  // Number of copied sign bits needed to widen an imm_w field to reg_w.
  function automatic int exts_pad_w(input int reg_w, input int imm_w);
    return (reg_w > imm_w) ? (reg_w - imm_w) : 0;
  endfunction

endpackage

// File: rtl/pu_addsub_core.sv
// Combinational add/subtract core.
// Ports: a_i, b_i operands; carry_i carry-in; sub_i selects A + ~B + carry_i;
// result_o sum, carry_o carry-out (1 = no borrow when subtracting),
// ov_o signed overflow of the addition actually performed, eq_o A == B,
// ltu_o / lts_o unsigned / signed A < B (valid in subtract mode with carry_i=1).
module pu_addsub_core #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         carry_i,
  input  logic         sub_i,
  output logic [W-1:0] result_o,
  output logic         carry_o,
  output logic         ov_o,
  output logic         eq_o,
  output logic         ltu_o,
  output logic         lts_o
);

  logic [W-1:0] bop;
  logic [W:0]   sum;

  assign bop      = sub_i ? ~b_i : b_i;
  assign sum      = {1'b0, a_i} + {1'b0, bop} + {{W{1'b0}}, carry_i};
  assign result_o = sum[W-1:0];
  assign carry_o  = sum[W];
  // Overflow is judged against the addend really fed to the adder.
  assign ov_o     = (a_i[W-1] == bop[W-1]) & (a_i[W-1] ^ sum[W-1]);
  assign eq_o     = (a_i == b_i);
  assign ltu_o    = ~sum[W];
  assign lts_o    = sum[W-1] ^ ov_o;

endmodule

// File: rtl/pu_add_cmp_pipe.sv
// Two-stage (EX, WB) pipelined add/sub/add-with-carry/compare processing unit.
// Claims opcodes SUB/ADD/ICMP/ADDC on the unique-ack daisy chain, accepts on
// i_valid & o_unique_ack & o_ready, and writes back a register or the compare
// flag under i_wb_ready backpressure. Keeps architectural carry/overflow flags.
// Ports: i_clk/i_rst clock and async active-high reset; i_valid/o_ready issue
// handshake; i_opcode, i_rega/i_regb/i_regd, i_imm, i_use_imm, i_cmp_op
// instruction fields; i_unique_ack/o_unique_ack claim chain; o_sela/o_selb and
// i_ina/i_inb register-file read; o_write_reg/o_write_data/o_write_en register
// writeback; o_flag_cmp/o_write_flag compare-flag writeback; i_wb_ready
// writeback accept; o_carry/o_overflow flags; o_trap overflow trap pulse.
// Build option: PU_ADD_CMP_OV_TRAP_EN suppresses the write of overflowing
// ADD/ADDC/SUB results and pulses o_trap when such an op retires.
module pu_add_cmp_pipe
  import pu_pkg::*;
#(
  parameter int OPTION_REG_WIDTH    = 64,
  parameter int OPTION_OPCODE_WIDTH = 6,
  parameter int OPTION_IMM_WIDTH    = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [OPTION_OPCODE_WIDTH-1:0] i_opcode,
  input  logic [4:0]                     i_rega,
  input  logic [4:0]                     i_regb,
  input  logic [4:0]                     i_regd,
  input  logic [OPTION_IMM_WIDTH-1:0]    i_imm,
  input  logic                           i_use_imm,
  input  logic [3:0]                     i_cmp_op,
  input  logic                           i_unique_ack,
  output logic                           o_unique_ack,
  output logic [4:0]                     o_sela,
  output logic [4:0]                     o_selb,
  input  logic [OPTION_REG_WIDTH-1:0]    i_ina,
  input  logic [OPTION_REG_WIDTH-1:0]    i_inb,
  output logic [4:0]                     o_write_reg,
  output logic [OPTION_REG_WIDTH-1:0]    o_write_data,
  output logic                           o_write_en,
  output logic                           o_flag_cmp,
  output logic                           o_write_flag,
  input  logic                           i_wb_ready,
  output logic                           o_carry,
  output logic                           o_overflow,
  output logic                           o_trap
);

  localparam int RW    = OPTION_REG_WIDTH;
  localparam int OW    = OPTION_OPCODE_WIDTH;
  localparam int PAD_W = exts_pad_w(OPTION_REG_WIDTH, OPTION_IMM_WIDTH);

  logic          match;
  alu_op_e       dec_op;
  logic [RW-1:0] imm_ext;
  logic          accept, ex_adv, wb_adv;

  logic          ex_valid_q;
  alu_op_e       ex_op_q;
  logic [4:0]    ex_regd_q;
  logic [3:0]    ex_cmp_q;
  logic [RW-1:0] ex_a_q, ex_b_q;

  logic          wb_valid_q, wb_is_cmp_q, wb_flag_q, wb_ov_q;
  logic [4:0]    wb_reg_q;
  logic [RW-1:0] wb_data_q;
  logic          carry_q, ov_q;

  logic          core_sub, core_cin, core_c, core_ov, core_eq, core_ltu, core_lts;
  logic [RW-1:0] core_r;
  logic          flag_d;

  always_comb begin
    match  = 1'b1;
    dec_op = ALU_ADD;
    case (i_opcode)
      OW'(OPC_SUB):  dec_op = ALU_SUB;
      OW'(OPC_ADD):  dec_op = ALU_ADD;
      OW'(OPC_ICMP): dec_op = ALU_ICMP;
      OW'(OPC_ADDC): dec_op = ALU_ADDC;
      default:       match  = 1'b0;
    endcase
  end

  generate
    if (PAD_W > 0) begin : g_exts
      assign imm_ext = {{PAD_W{i_imm[OPTION_IMM_WIDTH-1]}}, i_imm};
    end else begin : g_noext
      assign imm_ext = i_imm;
    end
  endgenerate

  assign wb_adv       = ~wb_valid_q | i_wb_ready;
  assign ex_adv       = ~ex_valid_q | wb_adv;
  assign o_ready      = ex_adv;
  assign o_unique_ack = i_valid & ~i_unique_ack & match;
  assign accept       = o_unique_ack & o_ready;
  assign o_sela       = i_rega;
  assign o_selb       = i_regb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= ALU_SUB;
      ex_regd_q  <= '0;
      ex_cmp_q   <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else if (ex_adv) begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_op_q   <= dec_op;
        ex_regd_q <= i_regd;
        ex_cmp_q  <= i_cmp_op;
        ex_a_q    <= i_ina;
        ex_b_q    <= i_use_imm ? imm_ext : i_inb;
      end
    end
  end

  // ADDC reads carry_q directly: the older op has already moved to WB and
  // updated the flag by the time ADDC sits in EX.
  assign core_sub = (ex_op_q == ALU_SUB) | (ex_op_q == ALU_ICMP);
  assign core_cin = (ex_op_q == ALU_ADDC) ? carry_q : core_sub;

  pu_addsub_core #(.W(RW)) u_core (
    .a_i      (ex_a_q),
    .b_i      (ex_b_q),
    .carry_i  (core_cin),
    .sub_i    (core_sub),
    .result_o (core_r),
    .carry_o  (core_c),
    .ov_o     (core_ov),
    .eq_o     (core_eq),
    .ltu_o    (core_ltu),
    .lts_o    (core_lts)
  );

  always_comb begin
    flag_d = 1'b0;
    if (ex_op_q == ALU_ICMP) begin
      case (ex_cmp_q)
        CMP_NEQ: flag_d = ~core_eq;
        CMP_GTU: flag_d = ~(core_eq | core_ltu);
        CMP_GTS: flag_d = ~(core_eq | core_lts);
        CMP_GEU: flag_d = ~core_ltu;
        CMP_GES: flag_d = ~core_lts;
        CMP_LTU: flag_d = core_ltu;
        CMP_LTS: flag_d = core_lts;
        CMP_LEU: flag_d = core_ltu | core_eq;
        CMP_LES: flag_d = core_lts | core_eq;
        CMP_EQ:  flag_d = core_eq;
        default: flag_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_valid_q  <= 1'b0;
      wb_is_cmp_q <= 1'b0;
      wb_flag_q   <= 1'b0;
      wb_ov_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      carry_q     <= 1'b0;
      ov_q        <= 1'b0;
    end else if (wb_adv) begin
      wb_valid_q <= ex_valid_q;
      if (ex_valid_q) begin
        wb_is_cmp_q <= (ex_op_q == ALU_ICMP);
        wb_flag_q   <= flag_d;
        wb_ov_q     <= core_ov & (ex_op_q != ALU_ICMP);
        wb_reg_q    <= ex_regd_q;
        wb_data_q   <= core_r;
        if (ex_op_q != ALU_ICMP) begin
          carry_q <= core_c;
          ov_q    <= core_ov;
        end
      end
    end
  end

  assign o_write_reg  = wb_reg_q;
  assign o_write_data = wb_data_q;
  assign o_flag_cmp   = wb_flag_q;
  assign o_write_flag = wb_valid_q & wb_is_cmp_q;
  assign o_carry      = carry_q;
  assign o_overflow   = ov_q;

`ifdef PU_ADD_CMP_OV_TRAP_EN
  assign o_write_en = wb_valid_q & ~wb_is_cmp_q & ~wb_ov_q;
  assign o_trap     = wb_valid_q & i_wb_ready & wb_ov_q;
`else
  logic unused_wb_ov;
  assign unused_wb_ov = wb_ov_q;
  assign o_write_en   = wb_valid_q & ~wb_is_cmp_q;
  assign o_trap       = 1'b0;
`endif

endmodule

// File: tb/tb_pu_add_cmp_pipe.sv
module tb_pu_add_cmp_pipe;

  localparam int W = 64;

  logic          i_clk, i_rst, i_valid, o_ready;
  logic [5:0]    i_opcode;
  logic [4:0]    i_rega, i_regb, i_regd;
  logic [15:0]   i_imm;
  logic          i_use_imm;
  logic [3:0]    i_cmp_op;
  logic          i_unique_ack, o_unique_ack;
  logic [4:0]    o_sela, o_selb;
  logic [W-1:0]  i_ina, i_inb;
  logic [4:0]    o_write_reg;
  logic [W-1:0]  o_write_data;
  logic          o_write_en, o_flag_cmp, o_write_flag, i_wb_ready;
  logic          o_carry, o_overflow, o_trap;

  pu_add_cmp_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rega(i_rega), .i_regb(i_regb), .i_regd(i_regd),
    .i_imm(i_imm), .i_use_imm(i_use_imm), .i_cmp_op(i_cmp_op),
    .i_unique_ack(i_unique_ack), .o_unique_ack(o_unique_ack),
    .o_sela(o_sela), .o_selb(o_selb), .i_ina(i_ina), .i_inb(i_inb),
    .o_write_reg(o_write_reg), .o_write_data(o_write_data), .o_write_en(o_write_en),
    .o_flag_cmp(o_flag_cmp), .o_write_flag(o_write_flag), .i_wb_ready(i_wb_ready),
    .o_carry(o_carry), .o_overflow(o_overflow), .o_trap(o_trap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_cmp;
    logic [4:0]  rd;
    logic [W-1:0] data;
    bit          flag;
    bit          carry;
    bit          ov;
    bit          trap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_carry  = 0;
  bit   m_ov     = 0;

  function automatic exp_t model(int op, logic [4:0] rd, logic [W-1:0] a,
                                 logic [W-1:0] b, logic [3:0] cmp);
    exp_t e;
    logic [W:0] s;
    e.rd = rd; e.is_cmp = (op == 3); e.flag = 0; e.trap = 0; e.data = '0;
    case (op)
      2: begin
        s = {1'b0, a} + {1'b0, b};
        e.data = s[W-1:0]; m_carry = s[W];
        m_ov = (a[W-1] == b[W-1]) && (e.data[W-1] != a[W-1]);
      end
      4: begin
        s = {1'b0, a} + {1'b0, b} + (W+1)'(m_carry);
        e.data = s[W-1:0]; m_carry = s[W];
        m_ov = (a[W-1] == b[W-1]) && (e.data[W-1] != a[W-1]);
      end
      1: begin
        e.data = a - b; m_carry = (a >= b);
        m_ov = (a[W-1] != b[W-1]) && (e.data[W-1] != a[W-1]);
      end
      default: begin
        e.data = a - b;
        case (cmp)
          4'd1:  e.flag = (a != b);
          4'd2:  e.flag = (a > b);
          4'd3:  e.flag = ($signed(a) > $signed(b));
          4'd4:  e.flag = (a >= b);
          4'd5:  e.flag = ($signed(a) >= $signed(b));
          4'd6:  e.flag = (a < b);
          4'd7:  e.flag = ($signed(a) < $signed(b));
          4'd8:  e.flag = (a <= b);
          4'd9:  e.flag = ($signed(a) <= $signed(b));
          4'd10: e.flag = (a == b);
          default: e.flag = 0;
        endcase
      end
    endcase
    e.trap  = (op != 3) && m_ov;
    e.carry = m_carry;
    e.ov    = m_ov;
    return e;
  endfunction

  // Scoreboard: one retirement per cycle with wb_valid & i_wb_ready.
  always @(negedge i_clk) begin
    if (!i_rst && i_wb_ready && (o_write_en || o_write_flag || o_trap)) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_retire: got write reg=%0d data=%h with nothing expected",
                 o_write_reg, o_write_data);
      end else begin
        exp_t e;
        bit exp_we, exp_tr;
        e = sb.pop_front();
`ifdef PU_ADD_CMP_OV_TRAP_EN
        exp_we = !e.is_cmp && !e.trap;
        exp_tr = e.trap;
`else
        exp_we = !e.is_cmp;
        exp_tr = 0;
`endif
        n_checks++;
        if (o_write_flag !== e.is_cmp) begin
          n_fail++; $display("FAIL write_flag: got %b expected %b", o_write_flag, e.is_cmp);
        end
        n_checks++;
        if (o_write_en !== exp_we) begin
          n_fail++; $display("FAIL write_en: got %b expected %b", o_write_en, exp_we);
        end
        n_checks++;
        if (o_trap !== exp_tr) begin
          n_fail++; $display("FAIL trap: got %b expected %b", o_trap, exp_tr);
        end
        n_checks++;
        if (o_write_reg !== e.rd) begin
          n_fail++; $display("FAIL write_reg: got %0d expected %0d", o_write_reg, e.rd);
        end
        if (e.is_cmp) begin
          n_checks++;
          if (o_flag_cmp !== e.flag) begin
            n_fail++; $display("FAIL flag_cmp: got %b expected %b", o_flag_cmp, e.flag);
          end
        end else if (exp_we) begin
          n_checks++;
          if (o_write_data !== e.data) begin
            n_fail++; $display("FAIL write_data: got %h expected %h", o_write_data, e.data);
          end
        end
        n_checks++;
        if (o_carry !== e.carry || o_overflow !== e.ov) begin
          n_fail++; $display("FAIL flags: got c=%b ov=%b expected c=%b ov=%b",
                             o_carry, o_overflow, e.carry, e.ov);
        end
      end
    end
  end

  task automatic issue(input int op, input logic [4:0] rd, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit use_imm, input logic [15:0] imm,
                       input logic [3:0] cmp);
    logic [W-1:0] bop;
    bit got;
    bop = use_imm ? {{(W-16){imm[15]}}, imm} : b;
    i_valid = 1; i_opcode = 6'(op); i_rega = rd + 5'd1; i_regb = rd + 5'd2; i_regd = rd;
    i_ina = a; i_inb = b; i_use_imm = use_imm; i_imm = imm; i_cmp_op = cmp;
    i_unique_ack = 0;
    sb.push_back(model(op, rd, a, bop, cmp));
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge i_clk);
      if (o_ready && o_unique_ack) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end else if (o_sela !== i_rega || o_selb !== i_regb) begin
      n_fail++; $display("FAIL selects: got %0d/%0d expected %0d/%0d", o_sela, o_selb, i_rega, i_regb);
    end
    @(posedge i_clk); #1;
    i_valid = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge i_clk);
      if (sb.size() == 0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1; i_valid = 0; i_opcode = 0; i_rega = 0; i_regb = 0; i_regd = 0;
    i_imm = 0; i_use_imm = 0; i_cmp_op = 0; i_unique_ack = 0; i_ina = 0; i_inb = 0;
    i_wb_ready = 1;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_write_en, o_write_flag, o_flag_cmp, o_trap, o_carry, o_overflow} !== 6'b0
        || o_write_data !== '0 || o_write_reg !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got we=%b wf=%b data=%h reg=%0d expected all 0",
                         o_write_en, o_write_flag, o_write_data, o_write_reg);
    end
    @(negedge i_clk); i_rst = 0;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_add();
    i_wb_ready = 1;
    issue(2, 5'd3, 64'd5, 64'd3, 0, 16'h0, 4'd0);
    @(negedge i_clk);
    n_checks++;
    if (o_write_en !== 1'b0) begin
      n_fail++; $display("FAIL add_latency_early: got we=%b expected 0", o_write_en);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_write_en !== 1'b1 || o_write_reg !== 5'd3 || o_write_data !== 64'd8 || o_carry !== 1'b0) begin
      n_fail++; $display("FAIL add_latency: got we=%b reg=%0d data=%h c=%b expected 1/3/8/0",
                         o_write_en, o_write_reg, o_write_data, o_carry);
    end
    drain();
  endtask

  task automatic test_back_to_back_addc();
    issue(2, 5'd4, '1, 64'd1, 0, 16'h0, 4'd0);
    issue(4, 5'd5, 64'd0, 64'd0, 0, 16'h0, 4'd0);
    drain();
    n_checks++;
    if (o_carry !== 1'b0) begin
      n_fail++; $display("FAIL addc_carry_after: got %b expected 0", o_carry);
    end
  endtask

  task automatic test_icmp();
    issue(2, 5'd6, '1, 64'd1, 0, 16'h0, 4'd0);
    issue(3, 5'd7, 64'h8000_0000_0000_0000, 64'd1, 0, 16'h0, 4'd3);
    issue(3, 5'd7, 64'h8000_0000_0000_0000, 64'd1, 0, 16'h0, 4'd2);
    issue(3, 5'd8, 64'd9, 64'd9, 0, 16'h0, 4'd10);
    issue(3, 5'd8, 64'd9, 64'd9, 0, 16'h0, 4'd15);
    drain();
  endtask

  task automatic test_sub_imm_overflow();
    issue(1, 5'd9, 64'd3, 64'd0, 1, 16'hFFFF, 4'd0);
    issue(1, 5'd10, 64'h7FFF_FFFF_FFFF_FFFF, '1, 0, 16'h0, 4'd0);
    drain();
    n_checks++;
    if (o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL sub_overflow: got %b expected 1", o_overflow);
    end
  endtask

  task automatic test_backpressure();
    i_wb_ready = 0;
    fork
      begin
        issue(2, 5'd11, 64'd10, 64'd1, 0, 16'h0, 4'd0);
        issue(1, 5'd12, 64'd10, 64'd1, 0, 16'h0, 4'd0);
        issue(3, 5'd13, 64'd10, 64'd1, 0, 16'h0, 4'd6);
      end
      begin
        logic [W-1:0] snap_d;
        logic [4:0]   snap_r;
        repeat (3) @(negedge i_clk);
        snap_d = o_write_data; snap_r = o_write_reg;
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (o_ready !== 1'b0 || o_write_en !== 1'b1 || o_write_data !== 64'd11 ||
              o_write_data !== snap_d || o_write_reg !== snap_r) begin
            n_fail++; $display("FAIL stall_stable: got rdy=%b we=%b data=%h expected 0/1/%h",
                               o_ready, o_write_en, o_write_data, 64'd11);
          end
          @(negedge i_clk);
        end
        @(posedge i_clk); #1;
        i_wb_ready = 1;
      end
    join
    drain();
  endtask

  task automatic test_no_claim();
    i_wb_ready = 1;
    i_valid = 1; i_opcode = 6'd2; i_unique_ack = 1; #1;
    n_checks++;
    if (o_unique_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_upstream: got %b expected 0", o_unique_ack);
    end
    i_unique_ack = 0; i_opcode = 6'd0; #1;
    n_checks++;
    if (o_unique_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_op0: got %b expected 0", o_unique_ack);
    end
    i_opcode = 6'd5; #1;
    n_checks++;
    if (o_unique_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_op5: got %b expected 0", o_unique_ack);
    end
    i_opcode = 6'd4; #1;
    n_checks++;
    if (o_unique_ack !== 1'b1) begin
      n_fail++; $display("FAIL ack_op4: got %b expected 1", o_unique_ack);
    end
    i_opcode = 6'd0;
    repeat (5) @(posedge i_clk);
    #1;
    i_valid = 0;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_claim_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_reset_midop();
    i_wb_ready = 0;
    issue(2, 5'd14, '1, 64'd1, 0, 16'h0, 4'd0);
    issue(2, 5'd15, 64'd1, 64'd1, 0, 16'h0, 4'd0);
    #2;
    n_checks++;
    if (o_write_en !== 1'b1 || o_carry !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got we=%b c=%b expected 1/1", o_write_en, o_carry);
    end
    i_rst = 1; #1;
    n_checks++;
    if ({o_write_en, o_write_flag, o_flag_cmp, o_trap, o_carry, o_overflow} !== 6'b0
        || o_write_data !== '0 || o_write_reg !== '0) begin
      n_fail++; $display("FAIL midop_reset: got we=%b c=%b data=%h reg=%0d expected all 0",
                         o_write_en, o_carry, o_write_data, o_write_reg);
    end
    sb.delete(); m_carry = 0; m_ov = 0;
    i_wb_ready = 1;
    @(negedge i_clk); i_rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_write_en !== 1'b0 || o_write_flag !== 1'b0 || o_ready !== 1'b1) begin
        n_fail++; $display("FAIL post_reset_idle: got we=%b wf=%b rdy=%b expected 0/0/1",
                           o_write_en, o_write_flag, o_ready);
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [W-1:0] a, b;
          int op;
          op = $urandom_range(1, 4);
          a  = {$urandom, $urandom};
          b  = {$urandom, $urandom};
          if ($urandom_range(0, 3) == 0) b = a;
          if ($urandom_range(0, 3) == 0) a = {1'b0, {(W-1){1'b1}}};
          issue(op, 5'($urandom_range(0, 31)), a, b, 1'($urandom_range(0, 1)),
                16'($urandom), 4'($urandom_range(0, 15)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge i_clk); #1;
          i_wb_ready = 1'($urandom_range(0, 1));
        end
        i_wb_ready = 1;
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back_addc();
    test_icmp();
    test_sub_imm_overflow();
    test_backpressure();
    test_no_claim();
    test_reset_midop();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pu_add_cmp_pipe.md
Name: pu_add_cmp_pipe

Overview:
Parametrised, two-stage pipelined integer add/subtract/compare processing unit. Sits in the processing-unit chain beside the other PUs and claims its opcodes through the unique-ack daisy chain. Adds a valid/ready issue handshake, writeback backpressure, sign-extended immediate operands, add-with-carry, and architectural carry/overflow flags. Signed greater-than is also implemented.

Parameters:
OPTION_REG_WIDTH, 64, datapath and register width (>= OPTION_IMM_WIDTH)
OPTION_OPCODE_WIDTH, 6, opcode width
OPTION_IMM_WIDTH, 16, immediate field width; sign-extended to OPTION_REG_WIDTH

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  control unit presents an instruction
o_ready  out  1  unit can accept this cycle
i_opcode  in  OPTION_OPCODE_WIDTH  SUB=1, ADD=2, ICMP=3, ADDC=4
i_rega / i_regb / i_regd  in  5 each  source A, source B, destination register numbers
i_imm  in  OPTION_IMM_WIDTH  immediate value
i_use_imm  in  1  operand B = exts(i_imm) instead of register B
i_cmp_op  in  4  compare selector: NEQ=1 GTU=2 GTS=3 GEU=4 GES=5 LTU=6 LTS=7 LEU=8 LES=9 EQ=10; any other value gives flag 0
i_unique_ack  in  1  an upstream unit already claims the op
o_unique_ack  out  1  this unit claims the op
o_sela / o_selb  out  5 each  register-file read selects (= i_rega / i_regb)
i_ina / i_inb  in  OPTION_REG_WIDTH each  register-file read data
o_write_reg  out  5  writeback destination
o_write_data  out  OPTION_REG_WIDTH  writeback data
o_write_en  out  1  register write request
o_flag_cmp  out  1  compare result
o_write_flag  out  1  compare-flag write request
i_wb_ready  in  1  writeback port accepts this cycle
o_carry / o_overflow  out  1 each  architectural carry and signed-overflow flags
o_trap  out  1  overflow trap pulse (see Optional Feature)

Behaviour:
- match = opcode in {1,2,3,4}. o_unique_ack = i_valid & !i_unique_ack & match (combinational, independent of o_ready). accept = o_unique_ack & o_ready. The control unit holds all inputs stable until accept.
- Stage EX register: captures opcode, regd, cmp_op, A = i_ina, and B = (i_use_imm ? exts(i_imm) : i_inb) on accept.
- Stage WB register: captures result, flag and control when EX advances.
- Advance and ready rules:
  - wb_adv = !wb_valid | i_wb_ready
  - ex_adv = !ex_valid | wb_adv
  - o_ready = ex_adv
  - Full throughput is one op per cycle. Latency is 2 cycles from the accept edge to o_write_en/o_write_flag.
- EX arithmetic (width OPTION_REG_WIDTH+1):
  - ADD: {c,r} = A + B
  - SUB and ICMP: {c,r} = A + ~B + 1 (c=1 means no borrow)
  - ADDC: {c,r} = A + B + o_carry
  - ov = (A[msb] == Bop[msb]) & (A[msb] ^ r[msb]), where Bop is the addend actually used (~B for SUB/ICMP).
- Compare flag (ICMP only), using the SUB datapath:
  - eq = (A == B); ltu = !c; lts = r[msb] ^ ov
  - GTU = !(eq|ltu); GTS = !(eq|lts); GEU = !ltu; GES = !lts; LEU = ltu|eq; LES = lts|eq
- o_carry and o_overflow update on the EX->WB transfer for ADD, ADDC and SUB only. ICMP leaves them unchanged.
  - ADDC in EX therefore always sees the flag of the immediately older op; no forwarding is needed.
- WB outputs:
  - o_write_en = wb_valid & op != ICMP.
  - o_write_flag = wb_valid & op == ICMP.
  - Outputs stay stable while i_wb_ready=0.
  - One write retires per cycle in which wb_valid & i_wb_ready.
- Reset (asynchronous, any time, including mid-operation):
  - ex_valid=0, wb_valid=0; in-flight ops are discarded.
  - o_carry=0, o_overflow=0, o_write_en=0, o_write_flag=0, o_flag_cmp=0, o_trap=0, o_write_data=0, o_write_reg=0.
  - o_ready=1 from the first clock edge after release.
- Unmatched opcodes and i_unique_ack=1: no accept; pipeline state unaffected.

Optional Feature:
PU_ADD_CMP_OV_TRAP_EN.
- Defined: an ADD/ADDC/SUB with ov=1 reaching WB keeps o_write_en=0 (the register is not written). o_overflow is still set. o_trap pulses high for exactly the one cycle in which that op retires (wb_valid & i_wb_ready).
- Undefined: o_trap is tied 0 and overflowing results are written normally.

Decomposition:
- Shared package pu_pkg: opcode constants, cmp_op index constants, and the sign-extension width helper. The other PUs reuse all of these.
- One sub-module, pu_addsub_core: combinational {c,r,ov,eq,lts,ltu} from A, B, carry-in and subtract mode. It is instantiated once in EX.

Test Plan:
1. ADD r1=5, r2=3 -> r3, i_wb_ready=1 -> o_write_en 2 cycles after accept; o_write_reg=3, o_write_data=8; o_carry=0.
2. ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1, then back-to-back ADDC A=0, B=0 -> first result 0 with o_carry=1; second result 1; o_carry=0 after the second op.
3. ICMP A=0x8000_0000_0000_0000, B=1 with cmp_op GTS, then GTU -> o_flag_cmp 0 then 1; o_write_flag=1; o_write_en=0; carry/overflow unchanged.
4. SUB A=3, i_use_imm=1, i_imm=0xFFFF -> 3-(-1)=4; SUB A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF -> o_overflow=1 (with the macro: no write, o_trap one cycle).
5. Three ops issued with i_wb_ready=0 for 4 cycles -> o_ready drops after two accepts; WB outputs stay stable; all three retire in order once i_wb_ready=1.
6. i_unique_ack=1, or opcode 0 -> o_unique_ack=0, no write. Assert i_rst with both stages valid -> all outputs 0 immediately; no write after release.
